// File: rtl/seq_div.sv
// seq_div -- multi-cycle restoring divider, one quotient bit per clock.
//
// Computes q = a / b and r = a % b for BW-bit operands behind valid/ready
// handshakes on both the operand and the result side.
//
// Parameters:
//   BW         operand / quotient / remainder width (2..64)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands a/b valid
//   in_ready   divider can accept operands (high only while idle)
//   a, b       dividend, divisor
//   signed_i   (SEQ_DIV_SIGNED_EN only) operands are two's complement
//   out_valid  q/r/dbz valid, held until out_ready
//   out_ready  consumer takes the result
//   q, r       quotient, remainder
//   dbz        divide-by-zero flag for the current result
//
// Build option: define SEQ_DIV_SIGNED_EN to add signed_i and truncating
// signed division (magnitudes are divided, signs fixed up on the last step).

module seq_div #(
    parameter int BW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
`ifdef SEQ_DIV_SIGNED_EN
    input  logic          signed_i,
`endif
    output logic          in_ready,
    input  logic [BW-1:0] a,
    input  logic [BW-1:0] b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BW-1:0] q,
    output logic [BW-1:0] r,
    output logic          dbz
);

    localparam int CW = $clog2(BW + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state;
    logic [BW-1:0] aa;       // shifting dividend, collects quotient bits
    logic [BW-1:0] bb;       // latched divisor (magnitude)
    logic [BW-1:0] pl;       // partial remainder
    logic [CW-1:0] cnt;      // remaining steps

    logic [BW:0]   sh;       // shifted partial remainder, one extra bit
    logic [BW:0]   t;
    logic [BW-1:0] pl_nxt;
    logic [BW-1:0] aa_nxt;
    logic [BW-1:0] a_mag;
    logic [BW-1:0] b_mag;
    logic [BW-1:0] q_fin;
    logic [BW-1:0] r_fin;

    // One restoring step. The shift is kept BW+1 bits wide so that a
    // divisor with its MSB set never loses the top bit of the remainder.
    always_comb begin
        sh = {pl, aa[BW-1]};
        t  = sh - {1'b0, bb};
        if (!t[BW]) begin
            pl_nxt = t[BW-1:0];
            aa_nxt = {aa[BW-2:0], 1'b1};
        end else begin
            pl_nxt = sh[BW-1:0];
            aa_nxt = {aa[BW-2:0], 1'b0};
        end
    end

`ifdef SEQ_DIV_SIGNED_EN
    logic neg_q;
    logic neg_r;

    always_comb begin
        a_mag = (signed_i && a[BW-1]) ? -a : a;
        b_mag = (signed_i && b[BW-1]) ? -b : b;
        // -2^(BW-1) has no positive counterpart; its magnitude as an
        // unsigned value is still correct, so the overflow case falls out.
        q_fin = neg_q ? -aa_nxt : aa_nxt;
        r_fin = neg_r ? -pl_nxt : pl_nxt;
    end
`else
    always_comb begin
        a_mag = a;
        b_mag = b;
        q_fin = aa_nxt;
        r_fin = pl_nxt;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            q         <= '0;
            r         <= '0;
            dbz       <= 1'b0;
            cnt       <= '0;
            aa        <= '0;
            bb        <= '0;
            pl        <= '0;
`ifdef SEQ_DIV_SIGNED_EN
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        aa       <= a_mag;
                        bb       <= b_mag;
                        pl       <= '0;
                        cnt      <= CW'(BW);
                        in_ready <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
                        neg_q    <= signed_i && (a[BW-1] ^ b[BW-1]);
                        neg_r    <= signed_i && a[BW-1];
`endif
                        if (b == '0) begin
                            // Result is known now; out_valid follows on
                            // the next edge from the DONE state.
                            state <= DONE;
                            q     <= '1;
                            r     <= a;
                            dbz   <= 1'b1;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end

                BUSY: begin
                    aa  <= aa_nxt;
                    pl  <= pl_nxt;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        q         <= q_fin;
                        r         <= r_fin;
                        dbz       <= 1'b0;
                    end
                end

                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
